// File: rtl/ysyx_24090018_pkg.sv
// Shared constants and state encoding for the instruction-fetch sequencer.
package ysyx_24090018_pkg;

  // Reset is active-low: rst equal to this value puts the block in reset.
  localparam logic ysyx_24090018_RstEnable = 1'b0;

  // Level of jump_flag that selects the redirect target.
  localparam logic ysyx_24090018_JumpEnable = 1'b1;

  // Architectural PC after reset.
  localparam logic [31:0] ysyx_24090018_PC_BaseAddr = 32'h8000_0000;

  // Sequential PC step (one 32-bit instruction).
  localparam int ysyx_24090018_PcIncr = 4;

  // Fetch sequencer states; codes 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_DELIVER  = 3'd3,
    S_EXEC     = 3'd4,
    S_FAULT    = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/ysyx_24090018_pc_en_reg.sv
// Enable-gated PC register: advances by one instruction or loads a jump
// target, and only when the sequencer grants an update.
module ysyx_24090018_pc_en_reg
  import ysyx_24090018_pkg::*;
#(
  parameter int              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(ysyx_24090018_PC_BaseAddr)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  jump_flag,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_next;

  // Next PC: redirect target or sequential step (wraps modulo 2^ADDR_WIDTH).
  always_comb begin
    pc_next = pc_o + ADDR_WIDTH'(ysyx_24090018_PcIncr);
    if (jump_flag == ysyx_24090018_JumpEnable) begin
      pc_next = jump_addr;
    end
  end

  // PC register with synchronous reset and update enable.
  always_ff @(posedge clk) begin
    if (rst == ysyx_24090018_RstEnable) begin
      pc_o <= RESET_PC;
    end else if (en) begin
      pc_o <= pc_next;
    end
  end

endmodule

// File: rtl/ysyx_24090018_fetch_ctrl.sv
// Handshake-driven instruction-fetch sequencer owning the architectural PC.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | just out of reset, moves to REQ on the next edge
// REQ      | fetch request for pc_o presented until memory accepts it
// WAIT_RSP | single outstanding request, waiting for the response
// DELIVER  | captured instruction offered to decode
// EXEC     | waiting for execute to commit, then PC advances or redirects
// FAULT    | access or alignment fault latched, only reset leaves
module ysyx_24090018_fetch_ctrl
  import ysyx_24090018_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(ysyx_24090018_PC_BaseAddr)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  commit_valid,
  input  logic                  jump_flag,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_pc
);

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic jump_taken;
  logic jump_misaligned;
  logic commit_ok;
  logic commit_bad;
  logic rsp_ok;
  logic rsp_bad;
  logic pc_en;

  assign jump_taken      = (jump_flag == ysyx_24090018_JumpEnable);
  assign jump_misaligned = jump_taken && (jump_addr[1:0] != 2'b00);

  // Qualified events; commit and response only count in their own state.
  assign commit_ok  = (state == S_EXEC) && commit_valid && !jump_misaligned;
  assign commit_bad = (state == S_EXEC) && commit_valid && jump_misaligned;
  assign rsp_ok     = (state == S_WAIT_RSP) && rsp_valid && !rsp_err;
  assign rsp_bad    = (state == S_WAIT_RSP) && rsp_valid && rsp_err;

  // A faulting target never reaches the PC; fault is also masked for safety.
  assign pc_en = commit_ok && !fault;

  ysyx_24090018_pc_en_reg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .en        (pc_en),
    .jump_flag (jump_flag),
    .jump_addr (jump_addr),
    .pc_o      (pc_o)
  );

  // State register; reset wins over any in-flight handshake.
  always_ff @(posedge clk) begin
    if (rst == ysyx_24090018_RstEnable) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        if (req_ready) begin
          state_nxt = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          state_nxt = rsp_err ? S_FAULT : S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (inst_ready) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (commit_valid) begin
          state_nxt = jump_misaligned ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Moore handshake outputs, decoded from the registered state only.
  assign req_valid  = (state == S_REQ);
  assign rsp_ready  = (state == S_WAIT_RSP);
  assign inst_valid = (state == S_DELIVER);
  assign req_addr   = pc_o;

  // Instruction capture and sticky fault bookkeeping.
  always_ff @(posedge clk) begin
    if (rst == ysyx_24090018_RstEnable) begin
      inst     <= '0;
      inst_pc  <= '0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      if (rsp_ok) begin
        inst    <= rsp_data;
        inst_pc <= pc_o;
      end
      if (rsp_bad) begin
        fault    <= 1'b1;
        fault_pc <= pc_o;
      end else if (commit_bad) begin
        fault    <= 1'b1;
        fault_pc <= jump_addr;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090018_fetch_ctrl.sv
// Self-checking bench for the fetch sequencer: directed scenarios followed
// by randomized instruction streams against a transaction-level PC model.
module tb_ysyx_24090018_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit_valid;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [31:0] pc_o;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: PC after every committed instruction, fault info.
  logic [31:0] exp_pc;
  logic        exp_fault;
  logic [31:0] exp_fault_pc;

  ysyx_24090018_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .commit_valid (commit_valid),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .pc_o         (pc_o),
    .fault        (fault),
    .fault_pc     (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_inputs();
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    rsp_err      = 1'b0;
    inst_ready   = 1'b0;
    commit_valid = 1'b0;
    jump_flag    = 1'b0;
    jump_addr    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'b0, rsp_ready}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    exp_pc       = RST_PC;
    exp_fault    = 1'b0;
    exp_fault_pc = '0;
    rst = 1'b1;
    step();
    chk("first_req_valid", {31'b0, req_valid}, 32'd1);
    chk("first_req_addr", req_addr, RST_PC);
  endtask

  // One instruction from REQ to the next REQ (or to FAULT). Entry and exit
  // are at a negedge with the sequencer presenting a request.
  task automatic fetch_one(input logic [31:0] data, input logic err,
                           input int rd, input int sd, input int id, input int cd,
                           input logic jmp, input logic [31:0] jaddr);
    int c0;
    c0 = cyc;
    chk("req_valid", {31'b0, req_valid}, 32'd1);
    chk("req_addr", req_addr, exp_pc);
    chk("req_rsp_ready", {31'b0, rsp_ready}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      req_ready = 1'b0;
      rsp_valid = 1'($urandom);
      rsp_data  = $urandom;
      step();
      chk("req_hold_valid", {31'b0, req_valid}, 32'd1);
      chk("req_hold_addr", req_addr, exp_pc);
    end
    req_ready = 1'b1;
    rsp_valid = 1'b0;
    step();
    req_ready = 1'b0;
    chk("wait_rsp_ready", {31'b0, rsp_ready}, 32'd1);
    chk("wait_req_valid", {31'b0, req_valid}, 32'd0);
    for (int i = 0; i < sd; i++) begin
      commit_valid = 1'($urandom);
      jump_flag    = 1'($urandom);
      jump_addr    = $urandom;
      step();
      chk("wait_hold", {31'b0, rsp_ready}, 32'd1);
      chk("wait_no_req", {31'b0, req_valid}, 32'd0);
    end
    commit_valid = 1'b0;
    jump_flag    = 1'b0;
    rsp_valid    = 1'b1;
    rsp_data     = data;
    rsp_err      = err;
    step();
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    if (err) begin
      exp_fault    = 1'b1;
      exp_fault_pc = exp_pc;
      chk("rsp_err_fault", {31'b0, fault}, 32'd1);
      chk("rsp_err_fault_pc", fault_pc, exp_fault_pc);
      chk("rsp_err_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rsp_err_rsp_ready", {31'b0, rsp_ready}, 32'd0);
      chk("rsp_err_pc", pc_o, exp_pc);
      return;
    end
    chk("dlv_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("dlv_inst", inst, data);
    chk("dlv_inst_pc", inst_pc, exp_pc);
    chk("dlv_rsp_ready", {31'b0, rsp_ready}, 32'd0);
    for (int i = 0; i < id; i++) begin
      inst_ready   = 1'b0;
      commit_valid = 1'($urandom);
      jump_flag    = 1'($urandom);
      jump_addr    = $urandom;
      step();
      chk("dlv_hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("dlv_hold_inst", inst, data);
      chk("dlv_hold_inst_pc", inst_pc, exp_pc);
      chk("dlv_hold_pc", pc_o, exp_pc);
    end
    commit_valid = 1'b0;
    jump_flag    = 1'b0;
    inst_ready   = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("exec_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("exec_req_valid", {31'b0, req_valid}, 32'd0);
    for (int i = 0; i < cd; i++) begin
      jump_flag = 1'($urandom);
      jump_addr = $urandom;
      step();
      chk("exec_hold_pc", pc_o, exp_pc);
      chk("exec_hold_req", {31'b0, req_valid}, 32'd0);
    end
    commit_valid = 1'b1;
    jump_flag    = jmp;
    jump_addr    = jaddr;
    step();
    commit_valid = 1'b0;
    jump_flag    = 1'b0;
    if (jmp && (jaddr % 4 != 0)) begin
      exp_fault    = 1'b1;
      exp_fault_pc = jaddr;
      chk("jmp_fault", {31'b0, fault}, 32'd1);
      chk("jmp_fault_pc", fault_pc, exp_fault_pc);
      chk("jmp_fault_pc_hold", pc_o, exp_pc);
      chk("jmp_fault_req", {31'b0, req_valid}, 32'd0);
      return;
    end
    exp_pc = jmp ? jaddr : exp_pc + 32'd4;
    chk("next_req_valid", {31'b0, req_valid}, 32'd1);
    chk("next_req_addr", req_addr, exp_pc);
    chk("instr_cycles", cyc - c0, 4 + rd + sd + id + cd);
  endtask

  // Terminal fault: hammer inputs and confirm nothing moves.
  task automatic fault_hold(input int n);
    for (int i = 0; i < n; i++) begin
      req_ready    = 1'($urandom);
      rsp_valid    = 1'($urandom);
      rsp_data     = $urandom;
      inst_ready   = 1'($urandom);
      commit_valid = 1'b1;
      jump_flag    = 1'($urandom);
      jump_addr    = $urandom & 32'hFFFF_FFFC;
      step();
      chk("flt_req_valid", {31'b0, req_valid}, 32'd0);
      chk("flt_rsp_ready", {31'b0, rsp_ready}, 32'd0);
      chk("flt_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("flt_fault", {31'b0, fault}, 32'd1);
      chk("flt_fault_pc", fault_pc, exp_fault_pc);
      chk("flt_pc", pc_o, exp_pc);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    exp_pc       = RST_PC;
    exp_fault    = 1'b0;
    exp_fault_pc = '0;

    // Zero-wait sequential stream, then an aligned jump.
    do_reset();
    fetch_one(32'h0000_0013, 1'b0, 0, 0, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h0010_0093, 1'b0, 0, 0, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h0020_0113, 1'b0, 0, 0, 0, 0, 1'b1, 32'h8000_0100);
    fetch_one(32'h0030_0193, 1'b0, 0, 0, 0, 0, 1'b0, 32'h0);

    // Back-pressure on every handshake.
    fetch_one(32'hCAFE_F00D, 1'b0, 3, 5, 2, 1, 1'b0, 32'h0);

    // PC wrap at the top of the address space.
    fetch_one(32'h1111_1111, 1'b0, 0, 0, 0, 0, 1'b1, 32'hFFFF_FFFC);
    fetch_one(32'h2222_2222, 1'b0, 0, 0, 0, 0, 1'b0, 32'h0);
    chk("wrap_pc", pc_o, 32'h0000_0000);

    // Access fault on the third fetch, then recovery through reset.
    do_reset();
    fetch_one(32'h0000_0013, 1'b0, 0, 1, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h0000_0013, 1'b0, 1, 0, 1, 0, 1'b0, 32'h0);
    fetch_one(32'hBAD0_BAD0, 1'b1, 0, 2, 0, 0, 1'b0, 32'h0);
    chk("err_fault_pc_abs", fault_pc, 32'h8000_0008);
    fault_hold(4);
    do_reset();

    // Misaligned jump target.
    fetch_one(32'h0000_0013, 1'b0, 0, 0, 0, 0, 1'b0, 32'h0);
    fetch_one(32'h0000_0013, 1'b0, 0, 0, 0, 2, 1'b1, 32'h8000_0102);
    chk("mis_fault_pc_abs", fault_pc, 32'h8000_0102);
    chk("mis_pc_abs", pc_o, 32'h8000_0004);
    fault_hold(4);

    // Reset during WAIT_RSP with a response on the bus.
    do_reset();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    chk("mid_wait_rsp_ready", {31'b0, rsp_ready}, 32'd1);
    rst       = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 32'h1234_5678;
    step();
    rsp_valid = 1'b0;
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_rsp_ready", {31'b0, rsp_ready}, 32'd0);
    chk("mid_rst_pc", pc_o, RST_PC);
    rst = 1'b1;
    step();
    chk("mid_rel_req_valid", {31'b0, req_valid}, 32'd1);
    exp_pc = RST_PC;
    fetch_one(32'h0000_0073, 1'b0, 0, 0, 3, 0, 1'b0, 32'h0);

    // Randomized instruction streams.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] r;
      logic [31:0] ja;
      logic        jmp;
      logic        err;
      r   = $urandom;
      jmp = ($urandom_range(0, 3) == 0);
      ja  = ($urandom_range(0, 7) == 0) ? r : (r & 32'hFFFF_FFFC);
      err = ($urandom_range(0, 15) == 0);
      fetch_one($urandom, err,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), jmp, ja);
      if (exp_fault) begin
        fault_hold(2);
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
